// File: rtl/mod_exp_if.sv
// Operand/result bundle for the mod_exp engine: start/done handshake plus
// the three operands and the result.
interface mod_exp_if #(
   parameter int WIDTH = 16
);
   logic             go;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] result;
   logic             done;

   modport master (output go, output m, output e, output n, input result, input done);
   modport slave  (input go, input m, input e, input n, output result, output done);
endinterface

// File: rtl/mod_exp.sv
// Iterative right-to-left modular exponentiation, result = m^e mod n, using two
// interleaved shift-add modular multipliers. Optional: MODEXP_EARLY_EXIT_EN.
module mod_exp #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   mod_exp_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_REDUCE, S_EXP, S_FINAL, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
   logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, exp_q, exp_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d;
   logic [WIDTH+1:0] p_q [2];
   logic [WIDTH+1:0] p_d [2];
   logic [WIDTH+1:0] step [2];
   logic [WIDTH-1:0] mul_a [2];
   logic [WIDTH-1:0] mul_b [2];
   logic             last_step;

   // One MSB-first step: P = 2P + (bit ? B : 0), then at most two
   // subtractions of n bring P back below n (P < n, B < n => 2P + B < 3n).
   function automatic logic [WIDTH+1:0] mod_step(input logic [WIDTH+1:0] p,
                                                 input logic             bit_i,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] nn);
      logic [WIDTH+1:0] t;
      logic [WIDTH+1:0] nx;
      nx = {2'b00, nn};
      t  = {p[WIDTH:0], 1'b0} + (bit_i ? {2'b00, b} : '0);
      if (t >= nx) t = t - nx;
      if (t >= nx) t = t - nx;
      return t;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mul
         assign step[gi] = mod_step(p_q[gi], mul_a[gi][cnt_q], mul_b[gi], n_q);
      end
   endgenerate

   // Multiplier 0 reduces m (m * 1) during REDUCE, then forms acc * base.
   always_comb begin
      mul_a[0] = (state_q == S_REDUCE) ? m_q : acc_q;
      mul_b[0] = (state_q == S_REDUCE) ? ONE : base_q;
      mul_a[1] = base_q;
      mul_b[1] = base_q;
   end

   assign last_step = (cnt_q == '0);

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      e_d      = e_q;
      n_d      = n_q;
      acc_d    = acc_q;
      base_d   = base_q;
      exp_d    = exp_q;
      result_d = result_q;
      done_d   = done_q;
      cnt_d    = cnt_q;
      iter_d   = iter_q;
      p_d[0]   = p_q[0];
      p_d[1]   = p_q[1];

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.go) begin
               m_d      = bus.m;
               e_d      = bus.e;
               n_d      = bus.n;
               done_d   = 1'b0;
               result_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            acc_d   = ONE;
            exp_d   = e_q;
            cnt_d   = CNT_MAX;
            p_d[0]  = '0;
            p_d[1]  = '0;
            state_d = S_REDUCE;
         end
         S_REDUCE: begin
            p_d[0] = step[0];
            cnt_d  = cnt_q - CNT_W'(1);
            if (last_step) begin
               base_d  = step[0][WIDTH-1:0];
               p_d[0]  = '0;
               cnt_d   = CNT_MAX;
               iter_d  = CNT_MAX;
               state_d = S_EXP;
`ifdef MODEXP_EARLY_EXIT_EN
               if (exp_q == '0) state_d = S_FINAL;
`endif
            end
         end
         S_EXP: begin
            p_d[0] = step[0];
            p_d[1] = step[1];
            cnt_d  = cnt_q - CNT_W'(1);
            if (last_step) begin
               if (exp_q[0]) acc_d = step[0][WIDTH-1:0];
               base_d = step[1][WIDTH-1:0];
               exp_d  = exp_q >> 1;
               p_d[0] = '0;
               p_d[1] = '0;
               cnt_d  = CNT_MAX;
               iter_d = iter_q - CNT_W'(1);
               if (iter_q == '0) state_d = S_FINAL;
`ifdef MODEXP_EARLY_EXIT_EN
               else if (exp_q[WIDTH-1:1] == '0) state_d = S_FINAL;
`endif
            end
         end
         S_FINAL: begin
            // acc starts at 1, which is not reduced when n <= 1.
            result_d = (n_q < WIDTH'(2)) ? '0 : acc_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         e_q      <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         base_q   <= '0;
         exp_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         iter_q   <= '0;
         for (int i = 0; i < 2; i++) p_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         e_q      <= e_d;
         n_q      <= n_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         iter_q   <= iter_d;
         for (int i = 0; i < 2; i++) p_q[i] <= p_d[i];
      end
   end

   assign bus.result = result_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: a square-and-multiply model plus a
// per-cycle monitor that tracks latency, done level and result hold.
module tb_mod_exp;
   localparam int W         = 16;
   localparam int FIXED_LAT = W * (W + 1) + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mod_exp_if #(.WIDTH(W)) bus ();
   mod_exp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks      = 0;
   int errors      = 0;
   int completions = 0;

   bit         active  = 1'b0;
   bit         have    = 1'b0;
   int         cyc     = 0;
   int         exp_lat = 0;
   logic [W-1:0] exp_res = '0;
   logic [W-1:0] op_m = '0, op_e = '0, op_n = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] mm, input logic [W-1:0] ee,
                                          input logic [W-1:0] nn);
      longint r, b, nl;
      nl = longint'(nn);
      if (nl < 2) return '0;
      r = 1;
      b = longint'(mm) % nl;
      for (int i = 0; i < W; i++) begin
         if (ee[i]) r = (r * b) % nl;
         b = (b * b) % nl;
      end
      return W'(r);
   endfunction

   function automatic int early_lat(input logic [W-1:0] ee);
      int h;
      h = -1;
      for (int i = 0; i < W; i++) if (ee[i]) h = i;
      return 2 + W + W * (h + 1);
   endfunction

   // Monitor: one look per cycle, 1 time unit after the rising edge.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk("reset_done", 32'(bus.done), 32'd0);
         chk("reset_result", 32'(bus.result), 32'd0);
         active = 1'b0;
         have   = 1'b0;
      end else if (bus.go && !active) begin
         active  = 1'b1;
         cyc     = 0;
         op_m    = bus.m;
         op_e    = bus.e;
         op_n    = bus.n;
         exp_res = model(bus.m, bus.e, bus.n);
`ifdef MODEXP_EARLY_EXIT_EN
         exp_lat = early_lat(bus.e);
`else
         exp_lat = FIXED_LAT;
`endif
         chk("done_fall_on_go", 32'(bus.done), 32'd0);
      end else if (active) begin
         cyc++;
         if (cyc < exp_lat) begin
            chk("done_low_while_busy", 32'(bus.done), 32'd0);
         end else begin
            chk("done_at_latency", 32'(bus.done), 32'd1);
            chk("result_vs_model", 32'(bus.result), 32'(exp_res));
            active = 1'b0;
            have   = 1'b1;
            completions++;
            $display("op m=%0d e=%0d n=%0d result=%0d model=%0d cycles=%0d",
                     op_m, op_e, op_n, bus.result, exp_res, cyc);
         end
      end else if (have) begin
         chk("done_hold", 32'(bus.done), 32'd1);
         chk("result_hold", 32'(bus.result), 32'(exp_res));
      end else begin
         chk("idle_done", 32'(bus.done), 32'd0);
         chk("idle_result", 32'(bus.result), 32'd0);
      end
   end

   // Called at a falling edge; go is sampled by the next rising edge.
   task automatic start(input logic [W-1:0] mm, input logic [W-1:0] ee, input logic [W-1:0] nn);
      bus.go = 1'b1;
      bus.m  = mm;
      bus.e  = ee;
      bus.n  = nn;
      @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic wait_comp(input int c0, input int lit);
      int k;
      k = 0;
      while (completions == c0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (completions == c0) begin
         checks++;
         errors++;
         $display("FAIL completion_timeout: got no done after %0d cycles, required done", k);
      end else if (lit >= 0) begin
         chk("literal_result", 32'(bus.result), 32'(lit));
      end
   endtask

   task automatic run_op(input logic [W-1:0] mm, input logic [W-1:0] ee,
                         input logic [W-1:0] nn, input int lit);
      int c0;
      c0 = completions;
      start(mm, ee, nn);
      wait_comp(c0, lit);
   endtask

   initial begin
      int c0;
      logic [W-1:0] rm, re, rn;
      bus.go = 1'b0;
      bus.m  = '0;
      bus.e  = '0;
      bus.n  = '0;
      rst    = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      chk("pin_model_9_3_55", 32'(model(16'd9, 16'd3, 16'd55)), 32'd14);
      chk("pin_model_4_13_497", 32'(model(16'd4, 16'd13, 16'd497)), 32'd445);
      chk("pin_model_100_2_55", 32'(model(16'd100, 16'd2, 16'd55)), 32'd45);
      chk("pin_early_lat_e3", 32'(early_lat(16'd3)), 32'd50);

      run_op(16'd9, 16'd3, 16'd55, 14);
      run_op(16'd4, 16'd13, 16'd497, 445);
      run_op(16'd100, 16'd2, 16'd55, 45);
      run_op(16'd7, 16'd0, 16'd55, 1);
      run_op(16'd1234, 16'd777, 16'd1, 0);
      run_op(16'd0, 16'd5, 16'd55, 0);
      run_op(16'd5, 16'd5, 16'd0, 0);
      run_op(16'd2, 16'd3, 16'd1000, 8);

      // Inputs and a stray go during the operation must be ignored.
      c0 = completions;
      start(16'd9, 16'd3, 16'd55);
      repeat (10) @(negedge clk);
      bus.go = 1'b1;
      bus.m  = 16'd2;
      bus.e  = 16'd7;
      bus.n  = 16'd11;
      @(negedge clk);
      bus.go = 1'b0;
      bus.m  = 16'd60000;
      wait_comp(c0, 14);

      // Reset in the middle of an operation.
      start(16'd9, 16'd3, 16'd55);
      repeat (99) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midop_reset_done", 32'(bus.done), 32'd0);
      chk("midop_reset_result", 32'(bus.result), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(16'd9, 16'd3, 16'd55, 14);

      for (int i = 0; i < 20; i++) begin
         rm = W'($urandom);
         rn = W'($urandom_range(65535, 2));
         re = (i % 2 == 0) ? W'($urandom) : W'($urandom_range(255, 0));
         run_op(rm, re, rn, -1);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
